div_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single iterative nonrestoring divider among NREQ requesters in the RSA decryption datapath. Typical requesters are the n0prime extended-Euclid unit and the R^2 mod n precompute unit. The arbiter latches the winner's operands and pulses the divider start. It waits for the divider done, with a watchdog, then routes quotient and remainder back with a per-requester done pulse. A zero divisor is intercepted and flagged without using the divider.

---
 rtl/div_arbiter_if.sv | 30 +++
 rtl/div_arbiter.sv | 77 +++++++
 tb/tb_div_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester and divider signals for div_arbiter.
// The slave modport is the arbiter; the master modport drives requests and the divider reply.
interface div_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 1025
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_q;
    logic [NREQ*WIDTH-1:0] req_m;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      quot;
    logic [WIDTH-1:0]      rem;
    logic                  err;
    logic                  busy;
    logic                  div_start;
    logic [WIDTH-1:0]      div_q;
    logic [WIDTH-1:0]      div_m;
    logic                  div_done;
    logic [WIDTH-1:0]      div_quot;
    logic [WIDTH-1:0]      div_rem;
    modport master (
        output req, req_q, req_m, div_done, div_quot, div_rem,
        input  gnt, done, quot, rem, err, busy, div_start, div_q, div_m
    );
    modport slave (
        input  req, req_q, req_m, div_done, div_quot, div_rem,
        output gnt, done, quot, rem, err, busy, div_start, div_q, div_m
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider among NREQ requesters,
// with zero-divisor interception and a watchdog on the divider completion.
module div_arbiter #(
    parameter int NREQ    = 2,
    parameter int WIDTH   = 1025,
    parameter int TIMEOUT = 2100
) (
    input logic         clk,
    input logic         rst,
    div_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ZERO, RESP} state_t;
    state_t           state, state_n;
    logic [PW-1:0]    ptr, owner, win;
    logic [CW-1:0]    cnt;
    logic             any, fin;
    logic [WIDTH-1:0] win_q, win_m;
    // Scan downwards so the requester closest to ptr is the last, winning assignment.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                win = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end
    assign win_q = bus.req_q[win * WIDTH +: WIDTH];
    assign win_m = bus.req_m[win * WIDTH +: WIDTH];
    assign fin   = state == WAIT && (bus.div_done || cnt == CW'(TIMEOUT - 1));
    always_comb begin
        state_n = state == IDLE  ? (any ? (win_m == '0 ? ZERO : ISSUE) : IDLE) :
                  state == ISSUE ? WAIT :
                  state == WAIT  ? (fin ? RESP : WAIT) :
                  state == ZERO  ? RESP : IDLE;
    end
    assign bus.gnt       = (state == IDLE && any && !rst) ? NREQ'(1) << win : '0;
    assign bus.done      = (state == RESP && !rst) ? NREQ'(1) << owner : '0;
    assign bus.div_start = state == ISSUE && !rst;
    assign bus.busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            bus.quot  <= '0;
            bus.rem   <= '0;
            bus.err   <= 1'b0;
            bus.div_q <= '0;
            bus.div_m <= '0;
        end else begin
            state <= state_n;
            cnt   <= state == ISSUE ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
            if (state == IDLE && any) begin
                owner     <= win;
                bus.div_q <= win_q;
                bus.div_m <= win_m;
            end
            // A completion coinciding with the watchdog expiry still delivers the result.
            if (fin) begin
                bus.quot <= bus.div_done ? bus.div_quot : '0;
                bus.rem  <= bus.div_done ? bus.div_rem : '0;
                bus.err  <= !bus.div_done;
            end else if (state == ZERO) begin
                bus.quot <= '1;
                bus.rem  <= bus.div_q;
                bus.err  <= 1'b1;
            end
            if (state == RESP)
                ptr <= owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed and randomized transactions against a transaction-level
// model of grant order, divider handshake timing and returned results.
module tb_div_arbiter;
    localparam int N = 3, W = 64, TO = 48;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    div_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();
    div_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int n_tests = 0, n_fail = 0, mptr = 0;
    logic [W-1:0] oq [N];
    logic [W-1:0] om [N];
    logic [W-1:0] lq = '0, lr = '0;
    logic         le = 1'b0;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic set_req(input int i, input logic [W-1:0] q, input logic [W-1:0] m);
        oq[i] = q;
        om[i] = m;
        bus.req_q[i*W +: W] = q;
        bus.req_m[i*W +: W] = m;
        bus.req[i] = 1'b1;
    endtask
    function automatic int winner();
        for (int k = 0; k < N; k++)
            if (bus.req[(mptr + k) % N]) return (mptr + k) % N;
        return 0;
    endfunction
    function automatic logic [W-1:0] rand_m();
        int r;
        r = $urandom_range(0, 7);
        return r == 0 ? '0 : r < 4 ? W'($urandom_range(1, 1000)) : {$urandom, $urandom};
    endfunction
    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 9);
        return r == 0 ? -1 : r == 1 ? TO - 1 : r == 2 ? TO - 2 : r == 3 ? TO : $urandom_range(0, 12);
    endfunction
    // Entered at the negedge of the grant cycle; returns at the negedge of the done cycle.
    // lat is the WAIT cycle index at which the divider answers (negative or >= TO: never in time).
    task automatic txn(input int lat, input bit rearm);
        int w;
        logic [W-1:0] q, m, eq, er;
        logic ee;
        w = winner();
        q = oq[w];
        m = om[w];
        chk("gnt", bus.gnt, W'(1) << w);
        chk("idle_busy", bus.busy, 0);
        @(posedge clk);
        #1 bus.req[w] = 1'b0;
        bus.div_done = 1'($urandom);
        bus.div_quot = {$urandom, $urandom};
        bus.div_rem  = {$urandom, $urandom};
        @(negedge clk);
        chk("start", bus.div_start, m != 0);
        chk("busy", bus.busy, 1);
        chk("gnt_off", bus.gnt, 0);
        chk("early_done", bus.done, 0);
        if (m != 0) begin
            chk("div_q", bus.div_q, q);
            chk("div_m", bus.div_m, m);
        end
        @(posedge clk);
        #1 if (rearm) bus.req[w] = 1'b1;
        eq = '1;
        er = q;
        ee = 1'b1;
        if (m != 0) begin
            bus.div_quot = q / m;
            bus.div_rem  = q % m;
            for (int k = 0; k < TO; k++) begin
                bus.div_done = (k == lat);
                @(negedge clk);
                chk("wait", {bus.busy, bus.done, bus.div_start}, {1'b1, N'(0), 1'b0});
                if (k == lat || k == TO - 1) break;
                @(posedge clk);
                #1;
            end
            ee = !(lat >= 0 && lat < TO);
            eq = ee ? '0 : q / m;
            er = ee ? '0 : q % m;
            @(posedge clk);
            #1 bus.div_done = 1'b0;
        end
        @(negedge clk);
        chk("done", bus.done, W'(1) << w);
        chk("quot", bus.quot, eq);
        chk("rem", bus.rem, er);
        chk("err", bus.err, ee);
        lq = eq;
        lr = er;
        le = ee;
        mptr = (w + 1) % N;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.req = '0;
        bus.req_q = '0;
        bus.req_m = '0;
        bus.div_done = 1'b0;
        bus.div_quot = '0;
        bus.div_rem = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {bus.gnt, bus.done, bus.err, bus.busy, bus.div_start}, 0);
        chk("rst_quot", bus.quot, 0);
        chk("rst_rem", bus.rem, 0);
        chk("rst_div_q", bus.div_q, 0);
        chk("rst_div_m", bus.div_m, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        // single request
        set_req(0, 64'h1_0000_0000, 64'd3);
        @(negedge clk);
        txn(40, 0);
        chk("plan_quot", bus.quot, 64'h5555_5555);
        chk("plan_rem", bus.rem, 64'd1);
        // zero divisor
        @(posedge clk);
        #1 set_req(1, 64'h1234, 64'd0);
        @(negedge clk);
        txn(0, 0);
        chk("plan_zrem", bus.rem, 64'h1234);
        // contention: both requesters re-raise one cycle after their grant
        @(posedge clk);
        #1 set_req(0, 64'd1000, 64'd7);
        set_req(1, 64'd999, 64'd10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fair_gnt", bus.gnt, (i % 2) ? 64'd2 : 64'd1);
            txn($urandom_range(0, 6), i < 2);
            @(posedge clk);
            #1;
        end
        // timeout, then a normal transaction
        set_req(2, 64'd5000, 64'd7);
        @(negedge clk);
        txn(-1, 0);
        @(posedge clk);
        #1 set_req(2, 64'd5001, 64'd7);
        @(negedge clk);
        txn(5, 0);
        // divider done coincides with watchdog expiry
        @(posedge clk);
        #1 set_req(0, 64'hdead_beef, 64'd16);
        @(negedge clk);
        txn(TO - 1, 0);
        // reset five cycles into WAIT
        @(posedge clk);
        #1 set_req(1, 64'hffff, 64'd9);
        @(negedge clk);
        chk("r_gnt", bus.gnt, 64'd2);
        @(posedge clk);
        #1 bus.req[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("r_done", bus.done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mptr = 0;
        lq = '0;
        lr = '0;
        le = 1'b0;
        @(negedge clk);
        chk("r_idle", {bus.busy, bus.gnt, bus.div_start, bus.done}, 0);
        chk("r_quot", bus.quot, 0);
        @(posedge clk);
        #1 bus.div_done = 1'b1;
        @(negedge clk);
        chk("r_stray", {bus.busy, bus.done}, 0);
        @(posedge clk);
        #1 bus.div_done = 1'b0;
        set_req(0, 64'd77, 64'd5);
        set_req(1, 64'd78, 64'd6);
        @(negedge clk);
        chk("r_prio", bus.gnt, 64'd1);
        txn(3, 0);
        // randomized traffic
        repeat (150) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (!bus.req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, {$urandom, $urandom}, rand_m());
            @(negedge clk);
            chk("hold_quot", bus.quot, lq);
            chk("hold_rem", bus.rem, lr);
            chk("hold_err", bus.err, le);
            chk("idle_done", bus.done, 0);
            if (bus.req == '0) chk("no_gnt", bus.gnt, 0);
            else txn(rand_lat(), 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
